multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Main control unit for the 8-bit multicycle processor. It sequences instruction fetch (four byte-wide IR loads), decode, execute, memory and writeback as a Moore state machine. Its ALU decoder turns opcode/funct into the datapath control word: mux selects, register/memory/IR enables and PC enable. It sits beside the datapath and drives every control input the processor top exposes to the bench.

## Interface
Parameters
- STATE_W, 4, width of the state register and of the `state` debug output.

Ports
- clk  in  1  processor clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset; sampled on rising `clk`.
- op  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag from datapath.
- memread  out  1  memory read strobe.
- memwrite  out  1  memory write strobe.
- alusrca  out  1  0 = PC, 1 = register A.
- alusrcb  out  2  00 = B, 01 = const 1, 10 = imm[7:0], 11 = imm[7:0] (branch offset).
- memtoreg  out  1  register write data: 0 = ALU out, 1 = memory data register.
- regdst  out  1  destination register: 0 = rt, 1 = rd.
- iord  out  1  memory address: 0 = PC, 1 = ALU out.
- regwrite  out  1  register file write enable.
- irwrite  out  4  one-hot IR byte load enables, bit n loads IR[8n+7:8n].
- pcsrc  out  2  next-PC source: 00 = ALU result, 01 = ALU out (branch target), 10 = jump address.
- pcen  out  1  pcwrite OR (branch AND zero).
- branch  out  1  asserted only in BEQEX.
- alucontrol  out  3  ALU function.
- state  out  STATE_W  current state encoding, for debug.

## Operation
- States: FETCH1–FETCH4, DECODE, MEMADR, LBRD, LBWR, SBWR, RTYPEEX, RTYPEWR, BEQEX, JEX, ADDIEX, ADDIWR. Encoded 0–14 in this order.
- Transitions:
  - FETCH1→FETCH2→FETCH3→FETCH4→DECODE.
  - DECODE: op 100000 (lb) or 101000 (sb) →MEMADR; 000000→RTYPEEX; 000100→BEQEX; 000010→JEX; 001000→ADDIEX. Any other op →FETCH1 (NOP, no writes).
  - MEMADR: lb→LBRD, sb→SBWR.
  - LBRD→LBWR.
  - RTYPEEX→RTYPEWR.
  - ADDIEX→ADDIWR.
  - LBWR, SBWR, RTYPEWR, BEQEX, JEX, ADDIWR→FETCH1.
- Outputs not listed below are 0. aluop is 00 (add) unless stated.
  - FETCHn: memread=1, irwrite=bit n-1, alusrcb=01, pcwrite=1, pcsrc=00.
  - DECODE: alusrcb=11.
  - MEMADR and ADDIEX: alusrca=1, alusrcb=10.
  - LBRD: memread=1, iord=1.
  - LBWR: regwrite=1, memtoreg=1.
  - SBWR: memwrite=1, iord=1.
  - RTYPEEX: alusrca=1, aluop=10.
  - RTYPEWR: regwrite=1, regdst=1.
  - BEQEX: alusrca=1, aluop=01, branch=1, pcsrc=01.
  - JEX: pcwrite=1, pcsrc=10.
  - ADDIWR: regwrite=1.
- ALU decode:
  - aluop 00 →010 (add); aluop 01 →110 (sub).
  - aluop 10 by funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111. Any other funct →101; writeback still occurs.
- Outputs are Moore (state-only), except pcen and alucontrol, which are combinational on zero and funct respectively.

## Timing
- Reset: with reset high at a rising edge, state←FETCH1. While reset is high, every output is forced to 0, including pcen, irwrite and state.
- Reset asserted mid-instruction aborts it at the next edge. No partial write occurs after that edge.
- Cycles per instruction, counted from FETCH1 entry:
  - lb 8.
  - sb, R-type, addi 7.
  - beq, j 6.
  - illegal op 5.
- Each IR byte loads on the edge ending its FETCHn cycle. PC increments by 1 on each of those four edges, so PC advances 4 per instruction.
- Branch is taken iff zero=1 during BEQEX. pcen then rises in the same cycle.

## Structure
- Shared package `mc_pkg`: state encoding constants; opcode constants (OP_LB, OP_SB, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI); funct constants; ALUCTL_* codes; ALUOP_* codes; alusrcb and pcsrc select codes. The datapath imports the same package.
- One sub-module: `alu_decoder` (aluop, funct → alucontrol), combinational. The FSM, output decode and pcen logic stay in `multicycle_ctrl`.

## Test plan
- Reset held 2 cycles, then released with op=000000 → all outputs 0 during reset. First cycle after release: state=0, memread=1, irwrite=0001, pcen=1. Next three cycles: irwrite 0010, 0100, 1000.
- op=100000 (lb) → state sequence 0,1,2,3,4,5,6,7,0. LBRD has iord=1, memread=1. LBWR has regwrite=1, memtoreg=1.
- op=000000, funct=101010 → RTYPEEX alucontrol=111. RTYPEWR has regwrite=1, regdst=1. Next FETCH1 in cycle 8.
- op=000100 with zero=1 → BEQEX pcen=1, pcsrc=01, alucontrol=110. Repeat with zero=0 → pcen=0, branch=1.
- op=111111 (illegal) → DECODE→FETCH1. No memwrite or regwrite in any cycle.
- Reset asserted in SBWR cycle → next edge state=0, memwrite=0 while reset is high. Normal fetch resumes after release.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the 8-bit multicycle processor: state encoding,
// opcode/funct constants, ALU codes, mux selects and the Moore control word.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH1  = 4'd0,
    FETCH2  = 4'd1,
    FETCH3  = 4'd2,
    FETCH4  = 4'd3,
    DECODE  = 4'd4,
    MEMADR  = 4'd5,
    LBRD    = 4'd6,
    LBWR    = 4'd7,
    SBWR    = 4'd8,
    RTYPEEX = 4'd9,
    RTYPEWR = 4'd10,
    BEQEX   = 4'd11,
    JEX     = 4'd12,
    ADDIEX  = 4'd13,
    ADDIWR  = 4'd14
  } state_t;

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALUCTL_AND = 3'b000;
  localparam logic [2:0] ALUCTL_OR  = 3'b001;
  localparam logic [2:0] ALUCTL_ADD = 3'b010;
  localparam logic [2:0] ALUCTL_BAD = 3'b101;
  localparam logic [2:0] ALUCTL_SUB = 3'b110;
  localparam logic [2:0] ALUCTL_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_ONE   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BROFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       memtoreg;
    logic       regdst;
    logic       iord;
    logic       regwrite;
    logic [3:0] irwrite;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
    logic [1:0] aluop;
  } ctrl_t;

  // Moore control word for a state; anything not set here stays 0.
  function automatic ctrl_t decode_ctrl(state_t s);
    ctrl_t c;
    c = '0;
    c.aluop = ALUOP_ADD;
    case (s)
      FETCH1, FETCH2, FETCH3, FETCH4: begin
        c.memread = 1'b1;
        c.irwrite = 4'b0001 << s;
        c.alusrcb = SRCB_ONE;
        c.pcwrite = 1'b1;
        c.pcsrc   = PCSRC_ALU;
      end
      DECODE:         c.alusrcb = SRCB_BROFF;
      MEMADR, ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
      end
      LBRD: begin
        c.memread = 1'b1;
        c.iord    = 1'b1;
      end
      LBWR: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      SBWR: begin
        c.memwrite = 1'b1;
        c.iord     = 1'b1;
      end
      RTYPEEX: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_FUNCT;
      end
      RTYPEWR: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
      end
      BEQEX: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_SUB;
        c.branch  = 1'b1;
        c.pcsrc   = PCSRC_ALUOUT;
      end
      JEX: begin
        c.pcwrite = 1'b1;
        c.pcsrc   = PCSRC_JUMP;
      end
      ADDIWR:  c.regwrite = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps aluop and the R-type funct field to the ALU function code.
module alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  // Unknown R-type functs still produce a defined code so writeback is harmless.
  always_comb begin
    alucontrol = ALUCTL_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALUCTL_ADD;
      ALUOP_SUB: alucontrol = ALUCTL_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alucontrol = ALUCTL_ADD;
          FUNCT_SUB: alucontrol = ALUCTL_SUB;
          FUNCT_AND: alucontrol = ALUCTL_AND;
          FUNCT_OR:  alucontrol = ALUCTL_OR;
          FUNCT_SLT: alucontrol = ALUCTL_SLT;
          default:   alucontrol = ALUCTL_BAD;
        endcase
      end
      default: alucontrol = ALUCTL_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle processor: four-byte fetch, decode,
// execute, memory and writeback, with a registered Moore control word.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               memread,
  output logic               memwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic               memtoreg,
  output logic               regdst,
  output logic               iord,
  output logic               regwrite,
  output logic [3:0]         irwrite,
  output logic [1:0]         pcsrc,
  output logic               pcen,
  output logic               branch,
  output logic [2:0]         alucontrol,
  output logic [STATE_W-1:0] state
);

  state_t     cur;
  ctrl_t      ctl;
  logic [2:0] aluctl;

  function automatic state_t next_state(state_t s, logic [5:0] opcode);
    state_t n;
    n = FETCH1;
    case (s)
      FETCH1:  n = FETCH2;
      FETCH2:  n = FETCH3;
      FETCH3:  n = FETCH4;
      FETCH4:  n = DECODE;
      DECODE: begin
        case (opcode)
          OP_LB, OP_SB: n = MEMADR;
          OP_RTYPE:     n = RTYPEEX;
          OP_BEQ:       n = BEQEX;
          OP_J:         n = JEX;
          OP_ADDI:      n = ADDIEX;
          default:      n = FETCH1;
        endcase
      end
      MEMADR:  n = (opcode == OP_LB) ? LBRD : SBWR;
      LBRD:    n = LBWR;
      RTYPEEX: n = RTYPEWR;
      ADDIEX:  n = ADDIWR;
      default: n = FETCH1;
    endcase
    return n;
  endfunction

  // The control word is registered alongside the state so it is valid from
  // the first cycle of each state, including FETCH1 right after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= FETCH1;
      ctl <= decode_ctrl(FETCH1);
    end else begin
      cur <= next_state(cur, op);
      ctl <= decode_ctrl(next_state(cur, op));
    end
  end

  alu_decoder u_alu_decoder (
    .aluop      (ctl.aluop),
    .funct      (funct),
    .alucontrol (aluctl)
  );

  // Reset blanks every output immediately, so an aborted instruction writes nothing.
  always_comb begin
    memread    = 1'b0;
    memwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    iord       = 1'b0;
    regwrite   = 1'b0;
    irwrite    = 4'b0000;
    pcsrc      = 2'b00;
    pcen       = 1'b0;
    branch     = 1'b0;
    alucontrol = 3'b000;
    state      = '0;
    if (!reset) begin
      memread    = ctl.memread;
      memwrite   = ctl.memwrite;
      alusrca    = ctl.alusrca;
      alusrcb    = ctl.alusrcb;
      memtoreg   = ctl.memtoreg;
      regdst     = ctl.regdst;
      iord       = ctl.iord;
      regwrite   = ctl.regwrite;
      irwrite    = ctl.irwrite;
      pcsrc      = ctl.pcsrc;
      pcen       = ctl.pcwrite | (ctl.branch & zero);
      branch     = ctl.branch;
      alucontrol = aluctl;
      state      = STATE_W'(cur);
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed instructions from the test
// plan followed by random instruction streams with random zero and resets.
module tb_multicycle_ctrl;

  localparam int ST_FETCH1  = 0;
  localparam int ST_DECODE  = 4;
  localparam int ST_MEMADR  = 5;
  localparam int ST_LBRD    = 6;
  localparam int ST_LBWR    = 7;
  localparam int ST_SBWR    = 8;
  localparam int ST_RTYPEEX = 9;
  localparam int ST_RTYPEWR = 10;
  localparam int ST_BEQEX   = 11;
  localparam int ST_JEX     = 12;
  localparam int ST_ADDIEX  = 13;
  localparam int ST_ADDIWR  = 14;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memread, memwrite, alusrca, memtoreg, regdst, iord, regwrite;
  logic       pcen, branch;
  logic [1:0] alusrcb, pcsrc;
  logic [3:0] irwrite;
  logic [2:0] alucontrol;
  logic [3:0] state;

  int checks;
  int failures;

  multicycle_ctrl #(.STATE_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .memread    (memread),
    .memwrite   (memwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .iord       (iord),
    .regwrite   (regwrite),
    .irwrite    (irwrite),
    .pcsrc      (pcsrc),
    .pcen       (pcen),
    .branch     (branch),
    .alucontrol (alucontrol),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // States an instruction walks through, counted from FETCH1.
  function automatic void stateSeq(input logic [5:0] opc, output int seq[$]);
    seq = {0, 1, 2, 3, 4};
    case (opc)
      6'b100000: seq = {seq, ST_MEMADR, ST_LBRD, ST_LBWR};
      6'b101000: seq = {seq, ST_MEMADR, ST_SBWR};
      6'b000000: seq = {seq, ST_RTYPEEX, ST_RTYPEWR};
      6'b000100: seq = {seq, ST_BEQEX};
      6'b000010: seq = {seq, ST_JEX};
      6'b001000: seq = {seq, ST_ADDIEX, ST_ADDIWR};
      default: ;
    endcase
  endfunction

  function automatic logic [2:0] rtypeAlu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b101;
    endcase
  endfunction

  // Packed as {memread,memwrite,alusrca,alusrcb,memtoreg,regdst,iord,regwrite,irwrite,pcsrc,pcen,branch,alucontrol}.
  function automatic logic [19:0] expVec(input int st, input logic z, input logic [5:0] f);
    logic mr, mw, asa, mtr, rd, io, rw, pe, br;
    logic [1:0] asb, ps;
    logic [3:0] irw;
    logic [2:0] alc;
    {mr, mw, asa, mtr, rd, io, rw, pe, br} = '0;
    asb = 2'b00; ps = 2'b00; irw = 4'b0000; alc = 3'b010;
    if (st < ST_DECODE) begin
      mr = 1'b1; asb = 2'b01; pe = 1'b1;
      irw = 4'b0001 << st;
    end
    case (st)
      ST_DECODE:  asb = 2'b11;
      ST_MEMADR, ST_ADDIEX: begin asa = 1'b1; asb = 2'b10; end
      ST_LBRD:    begin mr = 1'b1; io = 1'b1; end
      ST_LBWR:    begin rw = 1'b1; mtr = 1'b1; end
      ST_SBWR:    begin mw = 1'b1; io = 1'b1; end
      ST_RTYPEEX: begin asa = 1'b1; alc = rtypeAlu(f); end
      ST_RTYPEWR: begin rw = 1'b1; rd = 1'b1; end
      ST_BEQEX:   begin asa = 1'b1; alc = 3'b110; br = 1'b1; ps = 2'b01; pe = z; end
      ST_JEX:     begin pe = 1'b1; ps = 2'b10; end
      ST_ADDIWR:  rw = 1'b1;
      default: ;
    endcase
    return {mr, mw, asa, asb, mtr, rd, io, rw, irw, ps, pe, br, alc};
  endfunction

  function automatic logic [19:0] obsVec();
    return {memread, memwrite, alusrca, alusrcb, memtoreg, regdst, iord, regwrite,
            irwrite, pcsrc, pcen, branch, alucontrol};
  endfunction

  task automatic checkReset(input string tag);
    checkOutput({tag, "_state"}, 32'(state), 32'd0);
    checkOutput({tag, "_ctrl"}, 32'(obsVec()), 32'd0);
  endtask

  // Runs one instruction starting just after the negedge inside its FETCH1
  // cycle. zeroMode: 0/1 force zero, 2 random. abortAt >= 0 raises reset at that step.
  task automatic applyStimulus(input logic [5:0] opc, input logic [5:0] f,
                               input int zeroMode, input int abortAt);
    int seq[$];
    stateSeq(opc, seq);
    op = opc;
    funct = f;
    for (int i = 0; i < seq.size(); i++) begin
      zero = (zeroMode == 2) ? 1'($urandom) : 1'(zeroMode);
      if (i == abortAt) begin
        reset = 1'b1;
        #1;
        checkReset("abort");
        @(negedge clk);
        #1;
        checkReset("abort_edge");
        reset = 1'b0;
        return;
      end
      #1;
      checkOutput("state", 32'(state), 32'(seq[i]));
      checkOutput("ctrl", 32'(obsVec()), 32'(expVec(seq[i], zero, f)));
      @(negedge clk);
    end
  endtask

  initial begin
    logic [5:0] opTable [7];
    logic [5:0] rop, rf;
    int abortAt;
    checks = 0;
    failures = 0;
    opTable = '{6'b100000, 6'b101000, 6'b000000, 6'b000100, 6'b000010, 6'b001000, 6'b111111};
    reset = 1'b1;
    op = 6'b000000;
    funct = 6'b000000;
    zero = 1'b0;
    repeat (2) begin
      @(negedge clk);
      #1;
      checkReset("reset");
    end
    reset = 1'b0;
    $display("[TB] reset released, starting directed instructions");

    applyStimulus(6'b000000, 6'b100000, 2, -1);
    applyStimulus(6'b100000, 6'b000000, 2, -1);
    applyStimulus(6'b000000, 6'b101010, 2, -1);
    applyStimulus(6'b000000, 6'b111000, 2, -1);
    applyStimulus(6'b000100, 6'b000000, 1, -1);
    applyStimulus(6'b000100, 6'b000000, 0, -1);
    applyStimulus(6'b111111, 6'b000000, 2, -1);
    applyStimulus(6'b101000, 6'b000000, 2, 6);
    applyStimulus(6'b001000, 6'b000000, 2, -1);
    applyStimulus(6'b000010, 6'b000000, 2, -1);

    $display("[TB] starting random instruction stream");
    for (int n = 0; n < 200; n++) begin
      rop = opTable[$urandom_range(6)];
      if (rop == 6'b111111) rop = 6'($urandom);
      rf = ($urandom_range(1) == 1) ? 6'($urandom) : {3'b100, 3'($urandom_range(5))};
      abortAt = ($urandom_range(9) == 0) ? int'($urandom_range(7)) : -1;
      applyStimulus(rop, rf, 2, abortAt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
